pwm_bank: RTL
=============

# pwm_bank

Multi-channel PWM generator for the board LEDs. It generalises the single-pair prescaler/PWM design to `CHANNELS` outputs with `DUTY_WIDTH`-bit duty resolution. Duty and mode registers are double-buffered so updates never glitch a running period, and there is an optional per-channel "breathe" mode that ramps brightness automatically. It sits between the switch/register front end and the RGB (or wider) LED pins.

## Interface
- `CHANNELS`, 3, number of PWM outputs (≥1).
- `DUTY_WIDTH`, 8, duty and period-counter width; period = 2^DUTY_WIDTH ticks.
- `PRESCALER_WIDTH`, 12, width of the tick-divider limit.
- `clock`, input, 1, single system clock.
- `reset`, input, 1, asynchronous, active-low reset.
- `enable`, input, 1, global run enable.
- `limit`, input, `PRESCALER_WIDTH`, system clocks per PWM tick (0 and 1 both mean every clock).
- `wr_en`, input, 1, shadow-register write strobe.
- `wr_ch`, input, max(1,$clog2(CHANNELS)), target channel.
- `wr_duty`, input, `DUTY_WIDTH`, duty (static mode) or peak level (breathe mode).
- `wr_mode`, input, 1, 0 = static, 1 = breathe.
- `pwm`, output, `CHANNELS`, registered PWM outputs.
- `period_start`, output, 1, one-clock pulse at each period boundary.

## Operation
- **Prescaler.** `pcnt` counts 0..L-1, where L = max(`limit`,1). `tick` is asserted when `pcnt`==L-1, and `pcnt` then returns to 0. `limit` is sampled live; if a change puts `pcnt` ≥ L-1, the next clock ticks and wraps.
- **Period counter.** `cnt` (`DUTY_WIDTH` bits) increments on `tick` and wraps from all-ones to 0. The internal boundary event `bnd` = `tick` && `cnt`==all-ones. `period_start` is `bnd` registered.
- **Shadow write.** On `wr_en`, `shadow_duty[wr_ch]` ← `wr_duty` and `shadow_mode[wr_ch]` ← `wr_mode`. A write with `wr_ch` ≥ `CHANNELS` is ignored.
- **Active update.** On `bnd`, each `active_duty`/`active_mode` loads its shadow. A write in the same clock as `bnd` lands in the shadow only and takes effect at the following boundary.
- **Static output.** `pwm[i]` ← `cnt` < `active_duty[i]`. Duty 0 gives constant low. Duty all-ones gives high for 2^W-1 of 2^W ticks.
- **Breathe mode** (per channel; `level[i]` and `dir[i]` with up=1). On `bnd` with `active_mode[i]`=1:
  - If the channel was static at the previous boundary, `level` ← 0 and `dir` ← up.
  - Else if `dir` is up: `level`+1. When it reaches the peak (`active_duty`), `dir` ← down.
  - Else if `dir` is down: `level`-1. When it reaches 0, `dir` ← up.
  - If the peak is less than `level`: `level` ← peak and `dir` ← down.
  - Peak 0 holds `level` at 0.
  - Output is `pwm[i]` ← `cnt` < `level[i]`.
  - A full breathe cycle at peak P is 2P periods.
- **Disable.** While `enable`=0: `pcnt`, `cnt` and `level` are cleared, `dir` is set to up, `pwm` and `period_start` are 0, and active registers follow the shadows every clock. Shadow writes are still accepted. On re-enable, counting starts from `cnt`=0 and `pcnt`=0.

## Timing
- Reset (async, `reset`=0) clears every register: `pcnt`, `cnt`, shadows, actives, `level`, `dir`=up, `pwm`=0, `period_start`=0.
- `pwm` lags `cnt` by one clock (output register).
- `period_start` is high in the clock after the final tick of a period, coincident with `cnt`=0 becoming visible.
- A shadow written at clock k is visible on `pwm` from the first period that starts after k.
- Reset mid-period forces outputs low immediately. There is no partial-period completion.

## Configuration
- `PWM_BANK_BREATHE_EN` defined: breathe logic (`level`, `dir`, mode registers) is built as described above.
- `PWM_BANK_BREATHE_EN` not defined: the `wr_mode` port remains but is ignored, every channel is static, and no `level`/`dir`/mode registers are synthesised.

## Structure
- Package `pwm_bank_pkg` holds:
  - a mode typedef (`PWM_STATIC`, `PWM_BREATHE`);
  - a direction typedef (`DIR_UP`, `DIR_DOWN`);
  - a function computing the `wr_ch` width.
- Sub-module `pwm_tick_gen` contains the prescaler (`clock`, `reset`, `enable`, `limit` → `tick`), instantiated once.
- The per-channel compare, shadow and breathe logic is a generate loop in `pwm_bank`.

## Test plan
- **Reset.** Hold `reset`=0 mid-run → `pwm`=0 and `period_start`=0 asynchronously. Release → first `period_start` 1024 clocks after enable (`limit`=4, W=8).
- **Static duties.** Duties 0 / 64 / 255, `limit`=4 → per 1024-clock period, `pwm` high for 0 / 256 / 1020 clocks respectively.
- **Glitch-free update.** Write duty 200 mid-period, then 10 on the exact `bnd` clock → current period unchanged, next period 200, the one after 10.
- **Breathe.** Peak 3, breathe mode → high ticks per period: 0,1,2,3,2,1,0,1…. Lowering the peak to 1 while `level`=3 → next period high 1 tick, then 0.
- **Disable and bad channel.** Drop `enable` for 5 clocks → `pwm`=0 and counters restart. Write with `wr_ch`=3 (`CHANNELS`=3) → no channel changes.
- **`limit`=0 vs `limit`=1.** Identical waveforms with a period of 256 clocks.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared types and helpers for the multi-channel LED PWM bank.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pwm_bank_pkg;

   typedef enum logic {
      PWM_STATIC  = 1'b0,
      PWM_BREATHE = 1'b1
   } pwm_mode_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } pwm_dir_t;

   // Channel-select width; a single-channel bank still gets a 1-bit select.
   function automatic int ch_sel_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: divides the system clock down to one PWM tick every max(limit,1) clocks.
// Latency: tick is combinational from pcnt; a live limit change takes effect on the next clock.
// Backpressure: none; enable=0 holds the divider cleared and suppresses tick.
module pwm_tick_gen #(
   parameter int PRESCALER_WIDTH = 12
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [PRESCALER_WIDTH-1:0] limit,
   output logic                       tick
);

   localparam logic [PRESCALER_WIDTH-1:0] P_ONE = PRESCALER_WIDTH'(1);

   logic [PRESCALER_WIDTH-1:0] pcnt;
   logic [PRESCALER_WIDTH-1:0] last;

   // Terminal count; limit 0 and 1 both tick every clock. Using >= means a
   // limit lowered below the current count ticks and wraps on the next clock.
   always_comb begin
      last = (limit == '0) ? '0 : (limit - P_ONE);
      tick = enable && (pcnt >= last);
   end

   // Divider counter: cleared while disabled, wraps to 0 on every tick.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pcnt <= '0;
      else if (!enable || tick)
         pcnt <= '0;
      else
         pcnt <= pcnt + P_ONE;
   end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel LED PWM with double-buffered duty/mode; optional breathe ramp (PWM_BANK_BREATHE_EN).
// Latency: pwm lags the period counter by one clock; shadow writes apply at the next period boundary.
// Backpressure: none; writes are always accepted (bad channel dropped), enable=0 forces outputs low.
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter int CHANNELS        = 3,
   parameter int DUTY_WIDTH      = 8,
   parameter int PRESCALER_WIDTH = 12
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  enable,
   input  logic [PRESCALER_WIDTH-1:0]            limit,
   input  logic                                  wr_en,
   input  logic [ch_sel_width(CHANNELS)-1:0]     wr_ch,
   input  logic [DUTY_WIDTH-1:0]                 wr_duty,
   input  logic                                  wr_mode,
   output logic [CHANNELS-1:0]                   pwm,
   output logic                                  period_start
);

   localparam logic [DUTY_WIDTH-1:0] D_ONE = DUTY_WIDTH'(1);

   logic                  tick;
   logic                  bnd;
   logic [DUTY_WIDTH-1:0] cnt;
   logic [CHANNELS-1:0]   pwm_nxt;

   pwm_tick_gen #(
      .PRESCALER_WIDTH(PRESCALER_WIDTH)
   ) u_tick_gen (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .limit  (limit),
      .tick   (tick)
   );

   // Boundary: last tick of the period, i.e. the counter is about to wrap.
   always_comb bnd = tick && (cnt == '1);

   // Period counter: advances per tick, restarts from 0 whenever disabled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (!enable)
         cnt <= '0;
      else if (tick)
         cnt <= cnt + D_ONE;
   end

   // Output and boundary registers; bnd is already gated by enable via tick.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pwm          <= '0;
         period_start <= 1'b0;
      end else begin
         pwm          <= enable ? pwm_nxt : '0;
         period_start <= bnd;
      end
   end

`ifndef PWM_BANK_BREATHE_EN
   // Mode input has no effect in the static-only build.
   logic mode_unused;
   assign mode_unused = wr_mode;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic                  wr_hit;
      logic [DUTY_WIDTH-1:0] shadow_duty;
      logic [DUTY_WIDTH-1:0] active_duty;
      logic [DUTY_WIDTH-1:0] cmp_level;

      // Channels >= CHANNELS never match any i, so such writes fall away.
      assign wr_hit = wr_en && (int'(wr_ch) == i);

      // Shadow duty: written any time, including while disabled.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset)
            shadow_duty <= '0;
         else if (wr_hit)
            shadow_duty <= wr_duty;
      end

      // Active duty: takes the shadow only at a boundary (or continuously when idle).
      always_ff @(posedge clock or negedge reset) begin
         if (!reset)
            active_duty <= '0;
         else if (!enable || bnd)
            active_duty <= shadow_duty;
      end

`ifdef PWM_BANK_BREATHE_EN
      pwm_mode_t             shadow_mode;
      pwm_mode_t             active_mode;
      logic [DUTY_WIDTH-1:0] level;
      pwm_dir_t              dir;
      logic [DUTY_WIDTH-1:0] nxt_level;
      pwm_dir_t              nxt_dir;

      // Shadow mode travels with the shadow duty.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset)
            shadow_mode <= PWM_STATIC;
         else if (wr_hit)
            shadow_mode <= pwm_mode_t'(wr_mode);
      end

      // Active mode: same boundary/idle update rule as the duty.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset)
            active_mode <= PWM_STATIC;
         else if (!enable || bnd)
            active_mode <= shadow_mode;
      end

      // Next ramp step, judged against the peak being loaded at this boundary.
      always_comb begin
         nxt_level = level;
         nxt_dir   = dir;
         if (active_mode == PWM_STATIC) begin
            // Entering breathe from static always starts a fresh ramp.
            nxt_level = '0;
            nxt_dir   = DIR_UP;
         end else if (dir == DIR_UP) begin
            nxt_level = (level == '1) ? level : (level + D_ONE);
            nxt_dir   = (nxt_level >= shadow_duty) ? DIR_DOWN : DIR_UP;
         end else begin
            nxt_level = (level == '0) ? level : (level - D_ONE);
            nxt_dir   = (nxt_level == '0) ? DIR_UP : DIR_DOWN;
         end
         if (shadow_duty < nxt_level) begin
            nxt_level = shadow_duty;
            nxt_dir   = DIR_DOWN;
         end
         if (shadow_duty == '0) begin
            nxt_level = '0;
            nxt_dir   = DIR_UP;
         end
      end

      // Ramp state: stepped once per period while breathing, parked otherwise.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            level <= '0;
            dir   <= DIR_UP;
         end else if (!enable) begin
            level <= '0;
            dir   <= DIR_UP;
         end else if (bnd) begin
            if (shadow_mode == PWM_BREATHE) begin
               level <= nxt_level;
               dir   <= nxt_dir;
            end else begin
               level <= '0;
               dir   <= DIR_UP;
            end
         end
      end

      assign cmp_level = (active_mode == PWM_BREATHE) ? level : active_duty;
`else
      assign cmp_level = active_duty;
`endif

      assign pwm_nxt[i] = (cnt < cmp_level);
   end

endmodule
